blackjack_hand_engine: RTL and testbench

Card-dealing and scoring engine that sits opposite `blackjack_fsm`. It consumes the FSM's phase outputs (`dealing_cards`, `player_active`, `dealer_active`) plus the player `hit` button. It draws cards from a free-running pseudo-random source, accumulates both hands with soft-ace handling, and returns `player_score` / `dealer_score` to the FSM. The dealer draw-to-17 rule lives here; the FSM only watches the scores.

---
 rtl/blackjack_pkg.sv | 43 ++++
 rtl/card_lfsr.sv | 29 ++
 rtl/blackjack_hand_engine.sv | 141 ++++++++++++++
 tb/tb_blackjack_hand_engine.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared types, widths and card arithmetic for the blackjack hand engine.
package blackjack_pkg;

  localparam int SCORE_W   = 5;
  localparam int RANK_W    = 4;
  localparam int BLACKJACK = 21;

  localparam logic [RANK_W-1:0] RANK_ACE  = 4'd1;
  localparam logic [RANK_W-1:0] RANK_KING = 4'd13;
  localparam logic [15:0]       LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_COMMIT,
    S_SETTLE
  } engine_state_e;

  typedef enum logic [1:0] {
    M_DEAL,
    M_HIT,
    M_DEALER
  } draw_mode_e;

  function automatic logic [SCORE_W-1:0] card_value(input logic [RANK_W-1:0] rank);
    return (rank >= 4'd10) ? SCORE_W'(10) : SCORE_W'(rank);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  // An ace counts 11 only while that cannot push the hand past 21.
  function automatic logic [SCORE_W-1:0] hand_score(input logic [SCORE_W-1:0] hard,
                                                    input logic              has_ace);
    return (has_ace && hard <= SCORE_W'(BLACKJACK - 10)) ? hard + SCORE_W'(10) : hard;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running card source: Galois LFSR, rank rejection filter and debug inject mux.
module card_lfsr import blackjack_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inject_valid,
  input  logic [RANK_W-1:0] inject_rank,
  output logic [RANK_W-1:0] rank,
  output logic              rank_ok
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  // Injected ranks go through the same filter, so bad injects stall like misses.
  assign rank    = inject_valid ? inject_rank : lfsr_q[RANK_W-1:0];
  assign rank_ok = (rank >= RANK_ACE) && (rank <= RANK_KING);

endmodule

// File: rtl/blackjack_hand_engine.sv
// Deals, draws and scores the player and dealer hands on behalf of blackjack_fsm.
module blackjack_hand_engine import blackjack_pkg::*; #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          DEALER_STAND = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dealing_cards,
  input  logic               player_active,
  input  logic               dealer_active,
  input  logic               hit,
  input  logic               inject_valid,
  input  logic [RANK_W-1:0]  inject_rank,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] dealer_score,
  output logic               card_valid,
  output logic [RANK_W-1:0]  card_rank,
  output logic               card_to_dealer,
  output logic               busy
);

  engine_state_e      state_q;
  draw_mode_e         mode_q;
  logic [1:0]         deal_idx_q;
  logic               to_dealer_q;
  logic [RANK_W-1:0]  card_rank_q;
  logic               card_valid_q;
  logic               deal_in_q;
  logic               hit_in_q;
  logic [SCORE_W-1:0] p_hard_q;
  logic [SCORE_W-1:0] d_hard_q;
  logic               p_ace_q;
  logic               d_ace_q;

  logic [RANK_W-1:0]  src_rank;
  logic               src_ok;
  logic               deal_edge;
  logic               hit_edge;
  logic               dealer_low;

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .clk          (clk),
    .rst_n        (rst_n),
    .inject_valid (inject_valid),
    .inject_rank  (inject_rank),
    .rank         (src_rank),
    .rank_ok      (src_ok)
  );

  assign deal_edge  = dealing_cards & ~deal_in_q;
  assign hit_edge   = hit & ~hit_in_q;
  assign dealer_low = int'(dealer_score) < DEALER_STAND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= M_DEAL;
      deal_idx_q   <= 2'd0;
      to_dealer_q  <= 1'b0;
      card_rank_q  <= '0;
      card_valid_q <= 1'b0;
      deal_in_q    <= 1'b0;
      hit_in_q     <= 1'b0;
      p_hard_q     <= '0;
      d_hard_q     <= '0;
      p_ace_q      <= 1'b0;
      d_ace_q      <= 1'b0;
    end else begin
      deal_in_q    <= dealing_cards;
      hit_in_q     <= hit;
      card_valid_q <= 1'b0;
      // A new deal wins over everything, including a card about to commit.
      if (deal_edge) begin
        state_q <= S_CLEAR;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (hit_edge && player_active) begin
              state_q     <= S_DRAW;
              mode_q      <= M_HIT;
              to_dealer_q <= 1'b0;
            end else if (dealer_active && dealer_low) begin
              state_q     <= S_DRAW;
              mode_q      <= M_DEALER;
              to_dealer_q <= 1'b1;
            end
          end
          S_CLEAR: begin
            p_hard_q    <= '0;
            d_hard_q    <= '0;
            p_ace_q     <= 1'b0;
            d_ace_q     <= 1'b0;
            deal_idx_q  <= 2'd0;
            mode_q      <= M_DEAL;
            to_dealer_q <= 1'b0;
            state_q     <= S_DRAW;
          end
          S_DRAW: begin
            if (src_ok) begin
              card_rank_q  <= src_rank;
              card_valid_q <= 1'b1;
              state_q      <= S_COMMIT;
            end
          end
          S_COMMIT: begin
            if (to_dealer_q) begin
              d_hard_q <= sat_add(d_hard_q, card_value(card_rank_q));
              if (card_rank_q == RANK_ACE) d_ace_q <= 1'b1;
            end else begin
              p_hard_q <= sat_add(p_hard_q, card_value(card_rank_q));
              if (card_rank_q == RANK_ACE) p_ace_q <= 1'b1;
            end
            // Deal order alternates P, D, P, D.
            if (mode_q == M_DEAL && deal_idx_q != 2'd3) begin
              deal_idx_q  <= deal_idx_q + 2'd1;
              to_dealer_q <= ~to_dealer_q;
              state_q     <= S_DRAW;
            end else if (mode_q == M_DEALER) begin
              state_q <= S_SETTLE;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_SETTLE: begin
            if (dealer_active && dealer_low) state_q <= S_DRAW;
            else                             state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign player_score   = hand_score(p_hard_q, p_ace_q);
  assign dealer_score   = hand_score(d_hard_q, d_ace_q);
  assign card_valid     = card_valid_q;
  assign card_rank      = card_rank_q;
  assign card_to_dealer = to_dealer_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_blackjack_hand_engine.sv
// Randomized bench for blackjack_hand_engine against a card-list scoring model.
module tb_blackjack_hand_engine;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dealing_cards = 1'b0;
  logic       player_active = 1'b0;
  logic       dealer_active = 1'b0;
  logic       hit = 1'b0;
  logic       inject_valid = 1'b0;
  logic [3:0] inject_rank = 4'd0;
  logic [4:0] player_score;
  logic [4:0] dealer_score;
  logic       card_valid;
  logic [3:0] card_rank;
  logic       card_to_dealer;
  logic       busy;

  blackjack_hand_engine #(.SEED(SEED), .DEALER_STAND(17)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dealing_cards  (dealing_cards),
    .player_active  (player_active),
    .dealer_active  (dealer_active),
    .hit            (hit),
    .inject_valid   (inject_valid),
    .inject_rank    (inject_rank),
    .player_score   (player_score),
    .dealer_score   (dealer_score),
    .card_valid     (card_valid),
    .card_rank      (card_rank),
    .card_to_dealer (card_to_dealer),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // rank < 0 means the card must come from the LFSR rather than the inject port.
  typedef struct {
    int rank;
    bit dlr;
  } card_t;

  card_t       exp_q[$];
  int          p_cards[$];
  int          d_cards[$];
  int          card_cyc[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          card_cnt = 0;
  int          force_rank = -1;
  logic [15:0] m_lfsr = SEED;
  logic [3:0]  cand = 4'd0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int best_score(input int cards[$]);
    int hard;
    bit ace;
    hard = 0;
    ace  = 1'b0;
    foreach (cards[i]) begin
      hard += (cards[i] > 10) ? 10 : cards[i];
      if (hard > 31) hard = 31;
      if (cards[i] == 1) ace = 1'b1;
    end
    return (ace && hard + 10 <= 21) ? hard + 10 : hard;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_scores(input string tag);
    check_eq({tag, "_player_score"}, player_score, best_score(p_cards));
    check_eq({tag, "_dealer_score"}, dealer_score, best_score(d_cards));
  endtask

  task automatic push_card(input int rank, input bit dlr);
    card_t c;
    c.rank = rank;
    c.dlr  = dlr;
    exp_q.push_back(c);
  endtask

  task automatic drive_inject();
    if (force_rank >= 0) begin
      inject_valid = 1'b1;
      inject_rank  = 4'(force_rank);
    end else if (exp_q.size() == 0) begin
      inject_valid = 1'b1;
      inject_rank  = 4'd0;
    end else if (exp_q[0].rank < 0) begin
      inject_valid = 1'b0;
      inject_rank  = 4'd0;
    end else begin
      inject_valid = 1'b1;
      inject_rank  = 4'(exp_q[0].rank);
    end
  endtask

  task automatic step();
    card_t e;
    int    r;
    @(posedge clk);
    cyc++;
    cand   = m_lfsr[3:0];
    m_lfsr = rst_n ? lfsr_step(m_lfsr) : SEED;
    #1;
    if (card_valid === 1'b1) begin
      card_cnt++;
      card_cyc.push_back(cyc);
      $display("[TB] card %0d rank=%0d to_%s cyc=%0d", card_cnt, card_rank,
               card_to_dealer ? "dealer" : "player", cyc);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_card", card_valid, 0);
      end else begin
        e = exp_q.pop_front();
        r = (e.rank < 0) ? int'(cand) : e.rank;
        check_eq("card_rank", card_rank, r);
        check_eq("card_to_dealer", card_to_dealer, e.dlr);
        if (e.dlr) d_cards.push_back(r);
        else       p_cards.push_back(r);
      end
    end
    drive_inject();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 80) begin
      step();
      k++;
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_lfsr = SEED;
    exp_q.delete();
    p_cards.delete();
    d_cards.delete();
    dealing_cards = 1'b0;
    hit = 1'b0;
    player_active = 1'b0;
    dealer_active = 1'b0;
    force_rank = -1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic deal(input int r0, input int r1, input int r2, input int r3, input bit timing);
    int t;
    p_cards.delete();
    d_cards.delete();
    exp_q.delete();
    card_cyc.delete();
    push_card(r0, 1'b0);
    push_card(r1, 1'b1);
    push_card(r2, 1'b0);
    push_card(r3, 1'b1);
    drive_inject();
    dealing_cards = 1'b1;
    t = cyc;
    step();
    dealing_cards = 1'b0;
    if (timing) check_eq("deal_busy_next_cycle", busy, 1);
    wait_idle("deal_idle");
    if (timing) begin
      check_eq("deal_card_count", card_cyc.size(), 4);
      for (int i = 0; i < 4 && i < card_cyc.size(); i++)
        check_eq($sformatf("deal_card%0d_cycle", i), card_cyc[i] - t, 3 + 2 * i);
      check_eq("deal_idle_cycle", cyc - t, 10);
    end
    check_scores("deal");
  endtask

  task automatic do_hit(input int r);
    push_card(r, 1'b0);
    drive_inject();
    player_active = 1'b1;
    hit = 1'b1;
    step();
    hit = 1'b0;
    wait_idle("hit_idle");
    player_active = 1'b0;
  endtask

  // fixed_rank > 0 uses that rank for every dealer draw, otherwise random ranks.
  task automatic dealer_turn(input int fixed_rank);
    int pend[$];
    int r;
    int n;
    pend = d_cards;
    card_cyc.delete();
    while (best_score(pend) < 17) begin
      r = (fixed_rank > 0) ? fixed_rank : int'($urandom_range(1, 13));
      push_card(r, 1'b1);
      pend.push_back(r);
    end
    n = exp_q.size();
    drive_inject();
    dealer_active = 1'b1;
    step();
    wait_idle("dealer_idle");
    dealer_active = 1'b0;
    check_eq("dealer_draw_count", card_cyc.size(), n);
    for (int i = 1; i < card_cyc.size(); i++)
      check_eq("dealer_draw_spacing", card_cyc[i] - card_cyc[i-1], 3);
    check_scores("dealer");
  endtask

  initial begin
    int c0;
    int k;

    #2;
    check_eq("rst_player_score", player_score, 0);
    check_eq("rst_dealer_score", dealer_score, 0);
    check_eq("rst_card_valid", card_valid, 0);
    check_eq("rst_card_rank", card_rank, 0);
    check_eq("rst_card_to_dealer", card_to_dealer, 0);
    check_eq("rst_busy", busy, 0);
    apply_reset();

    // Initial deal with cycle-exact timing.
    deal(10, 9, 1, 7, 1'b1);
    check_eq("deal_soft21", player_score, 21);
    check_eq("deal_dealer16", dealer_score, 16);

    // Soft ace turning hard.
    deal(1, 4, 5, 6, 1'b0);
    check_eq("soft_ace_16", player_score, 16);
    do_hit(10);
    check_eq("ace_hard_16", player_score, 16);
    do_hit(9);
    check_eq("ace_hard_25", player_score, 25);

    // Dealer auto-draw from 16 takes exactly one card.
    deal(5, 10, 4, 6, 1'b0);
    dealer_turn(2);
    check_eq("dealer_18", dealer_score, 18);

    // dealer_active dropping mid-draw: in-flight card commits, then stop.
    deal(2, 2, 2, 2, 1'b0);
    c0 = card_cnt;
    push_card(3, 1'b1);
    drive_inject();
    dealer_active = 1'b1;
    step();
    dealer_active = 1'b0;
    wait_idle("dealer_drop_idle");
    check_eq("dealer_drop_cards", card_cnt - c0, 1);
    check_scores("dealer_drop");

    // Hit without player_active is ignored.
    c0 = card_cnt;
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    step();
    check_eq("hit_inactive_busy", busy, 0);
    check_eq("hit_inactive_cards", card_cnt - c0, 0);

    // Dropped hit while busy, then restart mid-deal in a DRAW cycle.
    p_cards.delete();
    d_cards.delete();
    exp_q.delete();
    push_card(2, 1'b0);
    push_card(3, 1'b1);
    push_card(4, 1'b0);
    push_card(5, 1'b1);
    drive_inject();
    c0 = card_cnt;
    dealing_cards = 1'b1;
    step();
    dealing_cards = 1'b0;
    player_active = 1'b1;
    hit = 1'b1;
    step();
    hit = 1'b0;
    k = 0;
    while (card_cnt - c0 < 2 && k < 20) begin
      step();
      k++;
    end
    player_active = 1'b0;
    step();
    p_cards.delete();
    d_cards.delete();
    exp_q.delete();
    push_card(6, 1'b0);
    push_card(7, 1'b1);
    push_card(8, 1'b0);
    push_card(9, 1'b1);
    drive_inject();
    dealing_cards = 1'b1;
    step();
    dealing_cards = 1'b0;
    wait_idle("restart_idle");
    check_eq("restart_total_cards", card_cnt - c0, 6);
    check_scores("restart");

    // Rejected inject ranks stall in DRAW without a card.
    c0 = card_cnt;
    force_rank = 0;
    drive_inject();
    player_active = 1'b1;
    hit = 1'b1;
    step();
    hit = 1'b0;
    repeat (5) step();
    check_eq("reject0_busy", busy, 1);
    check_eq("reject0_cards", card_cnt - c0, 0);
    force_rank = 14;
    drive_inject();
    repeat (5) step();
    check_eq("reject14_busy", busy, 1);
    check_eq("reject14_cards", card_cnt - c0, 0);
    force_rank = -1;
    push_card(5, 1'b0);
    drive_inject();
    wait_idle("reject_release_idle");
    player_active = 1'b0;
    check_eq("reject_release_cards", card_cnt - c0, 1);
    check_scores("reject");

    // Saturation at 31.
    deal(10, 2, 10, 3, 1'b0);
    for (int i = 0; i < 11; i++) begin
      do_hit(10);
      check_scores("sat");
    end
    check_eq("sat_31", player_score, 31);

    // Asynchronous reset while a card is in COMMIT.
    push_card(5, 1'b0);
    drive_inject();
    player_active = 1'b1;
    hit = 1'b1;
    step();
    hit = 1'b0;
    c0 = card_cnt;
    k = 0;
    while (card_cnt == c0 && k < 20) begin
      step();
      k++;
    end
    check_eq("arst_reached_commit", card_cnt - c0, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_player_score", player_score, 0);
    check_eq("arst_dealer_score", dealer_score, 0);
    check_eq("arst_card_valid", card_valid, 0);
    check_eq("arst_card_rank", card_rank, 0);
    check_eq("arst_card_to_dealer", card_to_dealer, 0);
    check_eq("arst_busy", busy, 0);
    apply_reset();

    // LFSR-sourced hits right after reset confirm the seed reload.
    for (int i = 0; i < 3; i++) do_hit(-1);
    check_scores("lfsr");

    // Randomized rounds.
    for (int round = 0; round < 12; round++) begin
      int nh;
      deal(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
           int'($urandom_range(1, 13)), int'($urandom_range(1, 13)), 1'b0);
      nh = int'($urandom_range(0, 3));
      for (int h = 0; h < nh; h++) begin
        do_hit(int'($urandom_range(1, 13)));
        check_scores("rand_hit");
      end
      dealer_turn(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
